// File: rtl/minesweeper_pkg.sv
// Shared board geometry, cell codes and display FSM state type for the 5x5 Minesweeper core.
package minesweeper_pkg;

  localparam int BOARD_W = 5;
  localparam int N_CELLS = 25;

  typedef logic [3:0] cell_code_t;

  localparam cell_code_t CELL_HIDDEN = 4'hF;
  localparam cell_code_t CELL_MINE   = 4'hE;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    CELLS,
    DONE
  } disp_state_e;

  function automatic logic [4:0] cell_index(input logic [2:0] row, input logic [2:0] col);
    return 5'(row) * 5'(BOARD_W) + 5'(col);
  endfunction

endpackage

// File: rtl/board_display_tx_if.sv
// Valid/ready beat stream carrying board display data from board_display_tx to the player side.
interface board_display_tx_if;
  import minesweeper_pkg::*;

  logic       out_valid;
  cell_code_t out_cell;
  logic [4:0] out_index;
  logic       out_sof;
  logic       out_eol;
  logic       out_eof;
  logic       in_ready;

  modport master (
    output out_valid, out_cell, out_index, out_sof, out_eol, out_eof,
    input  in_ready
  );

  modport slave (
    input  out_valid, out_cell, out_index, out_sof, out_eol, out_eof,
    output in_ready
  );

endinterface

// File: rtl/board_display_tx_cell_neighbor_count.sv
// Combinational count of mines in the 8-neighbourhood of (row, col), clipped at the board edges.
module cell_neighbor_count
  import minesweeper_pkg::*;
(
  input  logic [N_CELLS-1:0] mines,
  input  logic [2:0]         row,
  input  logic [2:0]         col,
  output logic [3:0]         count
);

  always_comb begin
    int rr;
    int cc;
    rr    = 0;
    cc    = 0;
    count = '0;
    for (int unsigned dr = 0; dr < 3; dr++) begin
      for (int unsigned dc = 0; dc < 3; dc++) begin
        rr = int'(row) + int'(dr) - 1;
        cc = int'(col) + int'(dc) - 1;
        if (!(dr == 1 && dc == 1) && rr >= 0 && rr < BOARD_W && cc >= 0 && cc < BOARD_W) begin
          if (mines[5'(rr * BOARD_W + cc)]) count = count + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/board_display_tx.sv
// Snapshots the board on a display strobe and streams a header beat plus 25 cell codes.
// Optional macro DISPLAY_REVEAL_MINES_EN: reveal un-cleared mines once the game has ended.
module board_display_tx
  import minesweeper_pkg::*;
(
  input  logic                  in_clka,
  input  logic                  in_restart,
  input  logic                  in_display,
  input  logic [N_CELLS-1:0]    in_mines,
  input  logic [N_CELLS-1:0]    in_cleared,
  input  logic                  in_gameover,
  input  logic                  in_win,
  board_display_tx_if.master    disp,
  output logic                  out_busy,
  output logic                  out_display_done
);

  disp_state_e        state_q, state_d;
  logic               valid_q, valid_d;
  logic [2:0]         row_q, row_d;
  logic [2:0]         col_q, col_d;
  logic [N_CELLS-1:0] mines_q, mines_d;
  logic [N_CELLS-1:0] cleared_q, cleared_d;
  logic               gameover_q, gameover_d;
  logic               win_q, win_d;

  logic [4:0]  idx;
  logic [3:0]  nb_count;
  cell_code_t  cell_code;
  logic        xfer;

  assign idx  = cell_index(row_q, col_q);
  assign xfer = valid_q & disp.in_ready;

  cell_neighbor_count u_nbr (
    .mines (mines_q),
    .row   (row_q),
    .col   (col_q),
    .count (nb_count)
  );

  always_comb begin
    cell_code = CELL_HIDDEN;
    if (cleared_q[idx] && mines_q[idx]) begin
      cell_code = CELL_MINE;
    end else if (cleared_q[idx]) begin
      cell_code = nb_count;
    end
`ifdef DISPLAY_REVEAL_MINES_EN
    else if ((gameover_q || win_q) && mines_q[idx]) begin
      cell_code = CELL_MINE;
    end
`else
`endif
  end

  // valid is registered, so HDR spends its first cycle raising it before the header can transfer
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    row_d      = row_q;
    col_d      = col_q;
    mines_d    = mines_q;
    cleared_d  = cleared_q;
    gameover_d = gameover_q;
    win_d      = win_q;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (in_display) begin
          mines_d    = in_mines;
          cleared_d  = in_cleared;
          gameover_d = in_gameover;
          win_d      = in_win;
          row_d      = '0;
          col_d      = '0;
          state_d    = HDR;
        end
      end
      HDR: begin
        valid_d = 1'b1;
        if (xfer) state_d = CELLS;
      end
      CELLS: begin
        valid_d = 1'b1;
        if (xfer) begin
          if (idx == 5'(N_CELLS - 1)) begin
            valid_d = 1'b0;
            state_d = DONE;
          end else if (col_q == 3'(BOARD_W - 1)) begin
            col_d = '0;
            row_d = row_q + 3'd1;
          end else begin
            col_d = col_q + 3'd1;
          end
        end
      end
      DONE: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge in_clka) begin
    if (in_restart) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      mines_q    <= '0;
      cleared_q  <= '0;
      gameover_q <= 1'b0;
      win_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      row_q      <= row_d;
      col_q      <= col_d;
      mines_q    <= mines_d;
      cleared_q  <= cleared_d;
      gameover_q <= gameover_d;
      win_q      <= win_d;
    end
  end

  assign disp.out_valid = valid_q;
  assign out_busy        = (state_q != IDLE);
  assign out_display_done = (state_q == DONE);

  always_comb begin
    disp.out_cell  = '0;
    disp.out_index = '0;
    disp.out_sof   = 1'b0;
    disp.out_eol   = 1'b0;
    disp.out_eof   = 1'b0;
    if (valid_q && state_q == HDR) begin
      disp.out_sof  = 1'b1;
      disp.out_cell = {2'b00, win_q, gameover_q};
    end else if (valid_q && state_q == CELLS) begin
      disp.out_cell  = cell_code;
      disp.out_index = idx;
      disp.out_eol   = (col_q == 3'(BOARD_W - 1));
      disp.out_eof   = (idx == 5'(N_CELLS - 1));
    end
  end

endmodule

// File: tb/tb_board_display_tx.sv
// Randomized self-checking bench for board_display_tx against a beat-list reference model.
module tb_board_display_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_display = 1'b0;
  logic [24:0] in_mines = '0;
  logic [24:0] in_cleared = '0;
  logic        in_gameover = 1'b0;
  logic        in_win = 1'b0;
  logic        busy;
  logic        display_done;

  board_display_tx_if bus ();

  board_display_tx dut (
    .in_clka          (clk),
    .in_restart       (rst),
    .in_display       (in_display),
    .in_mines         (in_mines),
    .in_cleared       (in_cleared),
    .in_gameover      (in_gameover),
    .in_win           (in_win),
    .disp             (bus),
    .out_busy         (busy),
    .out_display_done (display_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rmode = 0;
  int pat = 0;

  logic [3:0] exp_cell [0:25];
  logic [4:0] exp_idx  [0:25];
  logic       exp_sof  [0:25];
  logic       exp_eol  [0:25];
  logic       exp_eof  [0:25];
  logic [3:0] got_cell [0:25];
  logic       got_eol  [0:25];
  logic       got_eof  [0:25];

  int   ptr = 0;
  int   stalls = 0;
  int   start_cyc = 0;
  int   done_cnt = 0;
  bit   armed = 0;
  bit   prev_stall = 0;
  logic [3:0] prev_cell;
  logic [4:0] prev_idx;
  logic       prev_sof, prev_eol, prev_eof;

  task automatic check(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, expv, $time);
    end
  endtask

  // Reference: what a cell must show, from the game rules on a frozen board.
  function automatic logic [3:0] model_code(input logic [24:0] m, input logic [24:0] cl,
                                            input logic go, input logic w, input int k);
    int r;
    int c;
    int n;
    r = k / 5;
    c = k % 5;
    n = 0;
    if (cl[5'(k)] && m[5'(k)]) return 4'hE;
    if (cl[5'(k)]) begin
      for (int rr = r - 1; rr <= r + 1; rr++)
        for (int cc = c - 1; cc <= c + 1; cc++)
          if (rr >= 0 && rr < 5 && cc >= 0 && cc < 5 && !(rr == r && cc == c))
            if (m[5'(rr * 5 + cc)]) n++;
      return 4'(n);
    end
`ifdef DISPLAY_REVEAL_MINES_EN
    if ((go || w) && m[5'(k)]) return 4'hE;
`endif
    return 4'hF;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    pat++;
    if (rmode == 0)      bus.in_ready = 1'b1;
    else if (rmode == 1) bus.in_ready = (pat % 4 == 0) || (pat % 4 == 3);
    else                 bus.in_ready = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (rst) begin
      armed      = 0;
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_cell",  bus.out_cell,  prev_cell);
        check("stall_index", bus.out_index, prev_idx);
        check("stall_sof",   bus.out_sof,   prev_sof);
        check("stall_eol",   bus.out_eol,   prev_eol);
        check("stall_eof",   bus.out_eof,   prev_eof);
      end
      if (!armed) begin
        check("idle_valid", bus.out_valid, 0);
        check("idle_done",  display_done,  0);
      end else begin
        check("busy", busy, 1);
        if (bus.out_valid) begin
          if (ptr > 25) begin
            check("beat_overrun", ptr, 25);
          end else begin
            check("cell",  bus.out_cell,  exp_cell[ptr]);
            check("index", bus.out_index, exp_idx[ptr]);
            check("sof",   bus.out_sof,   exp_sof[ptr]);
            check("eol",   bus.out_eol,   exp_eol[ptr]);
            check("eof",   bus.out_eof,   exp_eof[ptr]);
            if (bus.in_ready) begin
              got_cell[ptr] = bus.out_cell;
              got_eol[ptr]  = bus.out_eol;
              got_eof[ptr]  = bus.out_eof;
              ptr++;
            end
          end
          if (!bus.in_ready) stalls++;
        end
        if (display_done) begin
          check("done_beats",   ptr, 26);
          check("done_latency", cyc - start_cyc, 27 + stalls);
          check("done_valid",   bus.out_valid, 0);
          armed = 0;
          done_cnt++;
        end
      end
      prev_stall = bus.out_valid && !bus.in_ready;
      prev_cell  = bus.out_cell;
      prev_idx   = bus.out_index;
      prev_sof   = bus.out_sof;
      prev_eol   = bus.out_eol;
      prev_eof   = bus.out_eof;
    end
  end

  task automatic start(input logic [24:0] m, input logic [24:0] cl, input logic go, input logic w);
    @(posedge clk); #1;
    in_mines    = m;
    in_cleared  = cl;
    in_gameover = go;
    in_win      = w;
    in_display  = 1'b1;
    exp_cell[0] = {2'b00, w, go};
    exp_idx[0]  = '0;
    exp_sof[0]  = 1'b1;
    exp_eol[0]  = 1'b0;
    exp_eof[0]  = 1'b0;
    for (int k = 0; k < 25; k++) begin
      exp_cell[k+1] = model_code(m, cl, go, w, k);
      exp_idx[k+1]  = 5'(k);
      exp_sof[k+1]  = 1'b0;
      exp_eol[k+1]  = (k % 5 == 4);
      exp_eof[k+1]  = (k == 24);
    end
    for (int k = 0; k < 26; k++) begin
      got_cell[k] = 4'h0;
      got_eol[k]  = 1'b0;
      got_eof[k]  = 1'b0;
    end
    ptr    = 0;
    stalls = 0;
    @(posedge clk); #1;
    in_display = 1'b0;
    start_cyc  = cyc;
    armed      = 1;
    @(negedge clk);
    check("hdr_not_before_n1", bus.out_valid, 0);
  endtask

  task automatic wait_done();
    int d0;
    int g;
    d0 = done_cnt;
    g  = 0;
    while (done_cnt == d0 && g < 400) begin
      @(posedge clk);
      g++;
    end
    check("done_timeout", done_cnt - d0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [24:0] m;
    logic [24:0] cl;
    int d0;
    int g;
    int eol_n;
    bus.in_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", bus.out_valid, 0);
    check("rst_cell",  bus.out_cell,  0);
    check("rst_index", bus.out_index, 0);
    check("rst_sof",   bus.out_sof,   0);
    check("rst_eol",   bus.out_eol,   0);
    check("rst_eof",   bus.out_eof,   0);
    check("rst_busy",  busy,          0);
    check("rst_done",  display_done,  0);
    rst = 1'b0;

    check("model_pin_t1", model_code(25'h0000007, 25'h40, 1'b0, 1'b0, 6), 3);
    check("model_pin_t2", model_code(25'h0001000, 25'h1000001, 1'b0, 1'b0, 24), 0);
    check("model_pin_t3", model_code(25'h0100008, 25'h8, 1'b1, 1'b0, 3), 14);

    rmode = 0;
    start(25'h0000007, 25'h0000040, 1'b0, 1'b0);
    wait_done();
    check("t1_header", got_cell[0], 4'h0);
    check("t1_cell6",  got_cell[7], 4'h3);
    check("t1_cell0",  got_cell[1], 4'hF);
    check("t1_cell2",  got_cell[3], 4'hF);
    check("t1_eof24",  got_eof[25], 1);

    start(25'h0001000, 25'h1000001, 1'b0, 1'b0);
    wait_done();
    check("t2_cell0",  got_cell[1],  4'h0);
    check("t2_cell24", got_cell[25], 4'h0);
    eol_n = 0;
    for (int k = 0; k < 26; k++) eol_n += int'(got_eol[k]);
    check("t2_eol_count", eol_n, 5);

    start(25'h0100008, 25'h0000008, 1'b1, 1'b0);
    wait_done();
    check("t3_header", got_cell[0], 4'h1);
    check("t3_cell3",  got_cell[4], 4'hE);
`ifdef DISPLAY_REVEAL_MINES_EN
    check("t3_cell20", got_cell[21], 4'hE);
`else
    check("t3_cell20", got_cell[21], 4'hF);
`endif

    rmode = 1;
    start(25'h0A51234, 25'h1F0F0F0, 1'b0, 1'b1);
    wait_done();

    rmode = 0;
    d0 = done_cnt;
    start(25'h0004411, 25'h1FFFFFF, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    in_mines = ~in_mines;
    in_cleared = '0;
    @(posedge clk); @(posedge clk); #1;
    in_display = 1'b1;
    @(posedge clk); #1;
    in_display = 1'b0;
    wait_done();
    repeat (40) @(posedge clk);
    check("t5_single_done", done_cnt - d0, 1);

    m  = 25'($urandom);
    cl = 25'($urandom);
    start(m, cl, 1'b1, 1'b0);
    g = 0;
    while (ptr != 11 && g < 100) begin
      @(posedge clk);
      g++;
    end
    check("t6_reach_cell10", ptr, 11);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6_valid_after_rst", bus.out_valid, 0);
    check("t6_busy_after_rst",  busy, 0);
    check("t6_done_after_rst",  display_done, 0);
    d0 = done_cnt;
    repeat (40) @(posedge clk);
    check("t6_no_done", done_cnt - d0, 0);
    start(m, cl, 1'b0, 1'b1);
    wait_done();

    for (int t = 0; t < 6; t++) begin
      rmode = 2;
      m  = 25'($urandom);
      cl = 25'($urandom);
      start(m, cl, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_done();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
